// File: rtl/rec_buf_rd_scan.sv
// rtl/rec_buf_rd_scan.sv - drain-side LCU sweep of the reconstruction store rd_1 port with skid FIFO
// Optional chroma sweep (U and V after luma) is enabled by defining REC_BUF_RD_SCAN_CHROMA_EN.
module rec_buf_rd_scan #(
    parameter int PIXEL_WIDTH = 8,
    parameter int FIFO_DEPTH  = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      rd_ena_o,
    output logic [1:0]                rd_sel_o,
    output logic [1:0]                rd_siz_o,
    output logic [3:0]                rd_4x4_x_o,
    output logic [3:0]                rd_4x4_y_o,
    output logic [4:0]                rd_idx_o,
    input  logic [PIXEL_WIDTH*32-1:0] rd_dat_i,
    output logic                      out_vld_o,
    input  logic                      out_rdy_i,
    output logic [1:0]                out_sel_o,
    output logic                      out_x_o,
    output logic [5:0]                out_y_o,
    output logic [PIXEL_WIDTH*32-1:0] out_dat_o
);
    localparam int DW = PIXEL_WIDTH * 32;
    localparam int EW = DW + 9;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

`ifdef REC_BUF_RD_SCAN_CHROMA_EN
    localparam logic [7:0] LAST_CNT = 8'd191;
`else
    localparam logic [7:0] LAST_CNT = 8'd127;
`endif

    logic [1:0]    r_state;
    logic [7:0]    r_cnt;
    logic          r_inflight;
    logic [1:0]    r_tag_sel;
    logic          r_tag_x;
    logic [5:0]    r_tag_y;
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_done;

    logic [2:0]    w_blk;
    logic [4:0]    w_idx;
    logic          w_luma;
    logic [1:0]    w_sel;
    logic          w_bx;
    logic          w_by;
    logic [CW:0]   w_occ;
    logic          w_rd_ena;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    // Scan counter: bits [7:5] pick the 32x32 block (4 luma quadrants, then U, V), [4:0] the row.
    assign w_blk  = r_cnt[7:5];
    assign w_idx  = r_cnt[4:0];
    assign w_luma = ~w_blk[2];
    assign w_bx   = w_luma & w_blk[0];
    assign w_by   = w_luma & w_blk[1];

`ifdef REC_BUF_RD_SCAN_CHROMA_EN
    assign w_sel = w_luma ? 2'd0 : (w_blk[0] ? 2'd3 : 2'd2);
`else
    assign w_sel = 2'd0;
`endif

    assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_rd_ena    = (r_state == S_SCAN) && (w_occ < FIFO_DEPTH[CW:0]);
    assign w_push      = r_inflight;
    assign w_pop       = (r_count != '0) && out_rdy_i;
    assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

    assign rd_ena_o   = w_rd_ena;
    assign rd_sel_o   = w_sel;
    assign rd_siz_o   = w_rd_ena ? 2'd3 : 2'd0;
    assign rd_4x4_x_o = {w_bx, 3'b000};
    assign rd_4x4_y_o = {w_by, 3'b000};
    assign rd_idx_o   = w_idx;

    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = r_done;
    assign out_vld_o = (r_count != '0);
    assign {out_sel_o, out_x_o, out_y_o, out_dat_o} = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_tag_sel  <= '0;
            r_tag_x    <= 1'b0;
            r_tag_y    <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_rd_ena;
            r_count    <= w_count_nxt;

            if (w_rd_ena) begin
                r_tag_sel <= w_sel;
                r_tag_x   <= w_bx;
                r_tag_y   <= {w_by, w_idx};
            end

            if (w_push) begin
                r_mem[r_wp] <= {r_tag_sel, r_tag_x, r_tag_y, rd_dat_i};
                r_wp        <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_SCAN;
                        r_cnt   <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_rd_ena) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // No reads issue in DRAIN, so an empty next count means nothing is left in flight.
                    if (w_count_nxt == '0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rec_buf_rd_scan.sv
// tb/tb_rec_buf_rd_scan.sv - scoreboard bench for rec_buf_rd_scan with store model and randomized ready
module tb_rec_buf_rd_scan;
    localparam int DW = 256;
`ifdef REC_BUF_RD_SCAN_CHROMA_EN
    localparam int NB = 192;
`else
    localparam int NB = 128;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, rd_ena_o;
    logic [1:0]    rd_sel_o, rd_siz_o;
    logic [3:0]    rd_4x4_x_o, rd_4x4_y_o;
    logic [4:0]    rd_idx_o;
    logic [DW-1:0] rd_dat_i = '0;
    logic          out_vld_o;
    logic          out_rdy_i = 1'b1;
    logic [1:0]    out_sel_o;
    logic          out_x_o;
    logic [5:0]    out_y_o;
    logic [DW-1:0] out_dat_o;

    rec_buf_rd_scan #(.PIXEL_WIDTH(8), .FIFO_DEPTH(3)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rd_ena_o(rd_ena_o), .rd_sel_o(rd_sel_o), .rd_siz_o(rd_siz_o),
        .rd_4x4_x_o(rd_4x4_x_o), .rd_4x4_y_o(rd_4x4_y_o), .rd_idx_o(rd_idx_o),
        .rd_dat_i(rd_dat_i), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
        .out_sel_o(out_sel_o), .out_x_o(out_x_o), .out_y_o(out_y_o), .out_dat_o(out_dat_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    sel;
        logic          x;
        logic [5:0]    y;
        logic [DW-1:0] dat;
    } beat_t;

    beat_t         exp_q[$];
    int            n_tests = 0, n_fail = 0;
    int            cyc = 0, t0 = 0, rdy_mode = 0;
    int            issued = 0, accepted = 0, n_beats = 0, n_done = 0;
    int            first_rd = -1, first_vld = -1, done_cyc = -1, issued50 = -1;
    logic [7:0]    seed = 8'd0;
    logic          pend_v = 1'b0;
    logic [DW-1:0] pend_dat = '0;
    logic          prev_stall = 1'b0;
    logic [264:0]  prev_head = '0;

    task automatic chk_n(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [264:0] act, input logic [264:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stored pixel row: every byte derived from the row's component coordinates and a per-sweep seed.
    function automatic logic [DW-1:0] mk_dat(input logic [1:0] sel, input logic x, input logic [5:0] y,
                                             input logic [7:0] sd);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < 32; i++) begin
            d[i*8 +: 8] = 8'(int'(y) * 3 + i * 5 + int'(sel) * 41 + int'(x) * 97 + int'(sd));
        end
        return d;
    endfunction

    task automatic build_exp();
        beat_t b;
        exp_q.delete();
        for (int by = 0; by < 2; by++)
            for (int bx = 0; bx < 2; bx++)
                for (int r = 0; r < 32; r++) begin
                    b.sel = 2'd0; b.x = bx[0]; b.y = 6'(by * 32 + r);
                    b.dat = mk_dat(b.sel, b.x, b.y, seed);
                    exp_q.push_back(b);
                end
`ifdef REC_BUF_RD_SCAN_CHROMA_EN
        for (int c = 2; c < 4; c++)
            for (int r = 0; r < 32; r++) begin
                b.sel = 2'(c); b.x = 1'b0; b.y = 6'(r);
                b.dat = mk_dat(b.sel, b.x, b.y, seed);
                exp_q.push_back(b);
            end
`endif
    endtask

    task automatic chk_zero(input string nm);
        chk_w(nm, {busy_o, done_o, rd_ena_o, rd_sel_o, rd_siz_o, rd_4x4_x_o, rd_4x4_y_o, rd_idx_o,
                   out_vld_o, out_sel_o, out_x_o, out_y_o, out_dat_o}, '0);
    endtask

    initial forever @(posedge clk) cyc++;

    // Store rd_1 port: one-cycle read latency; junk on the bus when no read was issued.
    initial forever begin
        @(posedge clk);
        #1;
        rd_dat_i = pend_v ? pend_dat : {8{$urandom}};
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       out_rdy_i = cyc[0];
            2:       out_rdy_i = (cyc - t0 >= 50);
            3:       out_rdy_i = 1'($urandom_range(0, 1));
            default: out_rdy_i = 1'b1;
        endcase
    end

    // Monitor: sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        pend_v = rd_ena_o;
        if (rd_ena_o)
            pend_dat = mk_dat(rd_sel_o, rd_4x4_x_o[3],
                              (rd_sel_o == 2'd0) ? {rd_4x4_y_o[3], rd_idx_o} : {1'b0, rd_idx_o}, seed);
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (rd_ena_o) begin
                issued++;
                if (first_rd < 0) first_rd = cyc;
                chk_n("rd_addr_legal", int'(rd_siz_o == 2'd3 &&
                      ((rd_sel_o == 2'd0) ? (rd_4x4_x_o[2:0] == 3'd0 && rd_4x4_y_o[2:0] == 3'd0)
                                          : (rd_sel_o[1] && rd_4x4_x_o == 4'd0 && rd_4x4_y_o == 4'd0))), 1);
                chk_n("outstanding_le3", int'(issued - accepted <= 3), 1);
            end
            if (rdy_mode == 2 && cyc == t0 + 49) issued50 = issued;
            if (out_vld_o) begin
                if (first_vld < 0) first_vld = cyc;
                if (prev_stall)
                    chk_w("head_stable", {out_sel_o, out_x_o, out_y_o, out_dat_o}, prev_head);
            end
            if (out_vld_o && out_rdy_i) begin
                if (exp_q.size() == 0) begin
                    chk_n("beat_extra", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk_w("beat", {out_sel_o, out_x_o, out_y_o, out_dat_o}, {e.sel, e.x, e.y, e.dat});
                end
                accepted++;
                n_beats++;
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
                chk_n("busy_low_at_done", int'(busy_o), 0);
            end
            prev_stall = out_vld_o && !out_rdy_i;
            prev_head  = {out_sel_o, out_x_o, out_y_o, out_dat_o};
        end
    end

    task automatic run_sweep(input int mode, input bit restart, input bit do_rst);
        seed = 8'($urandom);
        build_exp();
        issued = 0; accepted = 0; n_beats = 0; n_done = 0;
        first_rd = -1; first_vld = -1; done_cyc = -1; issued50 = -1;
        rdy_mode = mode;
        start_i = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        while (n_done == 0 && cyc < t0 + 3000) begin
            start_i = restart && (cyc == t0 + 10);
            if (do_rst && cyc == t0 + 60) rstn = 1'b0;
            @(posedge clk);
            #1;
            if (!rstn) begin
                rstn = 1'b1;
                chk_zero("mid_reset_outputs");
                exp_q.delete();
                break;
            end
        end
        start_i = 1'b0;
        if (do_rst) begin
            repeat (5) @(posedge clk);
            #1;
            chk_n("no_done_after_reset", n_done, 0);
            chk_n("idle_after_reset", int'(busy_o), 0);
            return;
        end
        chk_n("done_seen", n_done, 1);
        chk_n("beat_count", n_beats, NB);
        chk_n("exp_empty", exp_q.size(), 0);
        if (mode == 0) begin
            chk_n("first_rd_cycle", first_rd - t0, 1);
            chk_n("first_vld_cycle", first_vld - t0, 3);
            chk_n("done_cycle", done_cyc - t0, NB + 3);
        end
        if (mode == 2) chk_n("reads_during_stall", issued50, 3);
        repeat (6) @(posedge clk);
        #1;
        chk_n("single_done", n_done, 1);
        chk_n("idle_after_done", int'(busy_o), 0);
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_outputs");
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("idle_outputs");
        run_sweep(0, 1'b0, 1'b0);
        run_sweep(1, 1'b0, 1'b0);
        run_sweep(2, 1'b0, 1'b0);
        run_sweep(0, 1'b1, 1'b0);
        run_sweep(3, 1'b0, 1'b0);
        run_sweep(3, 1'b0, 1'b0);
        run_sweep(0, 1'b0, 1'b1);
        run_sweep(0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
